// File: rtl/raster_pkg.sv
// raster_pkg: shared raster-setup types and constants.
//   EFMSB      MSB index of signed value/slope words (19-bit words)
//   SPAN_W     width of a span length field (legal lengths 1..MAX_SPAN)
//   MAX_SPAN   width of the interpolation tree fed by the span setup
//   coord_t    signed value/slope word
//   state_t    span setup FSM states
package raster_pkg;

  localparam int unsigned EFMSB    = 18;
  localparam int unsigned SPAN_W   = 7;
  localparam int unsigned MAX_SPAN = 64;

  typedef logic signed [EFMSB:0] coord_t;

  localparam coord_t COORD_MAX = {1'b0, {EFMSB{1'b1}}};
  localparam coord_t COORD_MIN = {1'b1, {EFMSB{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/span_slope_setup_if.sv
// span_slope_setup_if: input and output valid/ready channels of the span setup.
//   in_valid/in_ready         request handshake
//   in_v0, in_v1, in_len      start value, end value, span length
//   out_valid/out_ready       result handshake
//   out_left, out_mul         interpolation base value and slope
//   out_sat, out_err          slope clipped / zero length presented
// Modports: master drives requests and accepts results (upstream/downstream
// side), slave is the span setup block itself.
interface span_slope_setup_if;
  import raster_pkg::*;

  logic              in_valid;
  logic              in_ready;
  coord_t            in_v0;
  coord_t            in_v1;
  logic [SPAN_W-1:0] in_len;
  logic              out_valid;
  logic              out_ready;
  coord_t            out_left;
  coord_t            out_mul;
  logic              out_sat;
  logic              out_err;

  modport master (
    output in_valid, in_v0, in_v1, in_len, out_ready,
    input  in_ready, out_valid, out_left, out_mul, out_sat, out_err
  );

  modport slave (
    input  in_valid, in_v0, in_v1, in_len, out_ready,
    output in_ready, out_valid, out_left, out_mul, out_sat, out_err
  );

endinterface

// File: rtl/span_slope_setup_udiv_seq.sv
// udiv_seq: unsigned iterative restoring divider, one quotient bit per cycle,
// MSB first. start_i is accepted when idle; done_o pulses for one cycle once
// DVD_W iterations have completed, with quotient_o valid from then on.
//   clk_i, rst_i     clock, synchronous active-high reset (aborts a divide)
//   start_i          load dividend_i/divisor_i and begin
//   dividend_i       DVD_W-bit unsigned dividend
//   divisor_i        DVS_W-bit unsigned divisor (non-zero)
//   busy_o, done_o   iterating / final iteration just completed
//   quotient_o       DVD_W-bit quotient
module udiv_seq #(
  parameter int unsigned DVD_W = 20,
  parameter int unsigned DVS_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   trial;

  // quo_q starts as the dividend and is shifted out MSB first while the
  // quotient bits are shifted in at the bottom.
  always_comb begin
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[DVD_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (busy_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = trial[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DVS_W-1:0];
        quo_d = {quo_q[DVD_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      rem_d  = '0;
      dvs_d  = divisor_i;
      quo_d  = dividend_i;
      cnt_d  = CNT_W'(DVD_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/span_slope_setup.sv
// span_slope_setup: per-span setup for the 64-wide linear interpolation tree.
// Produces LEFT = V0 and MUL = (V1 - V0) / LEN (truncated toward zero,
// saturated to the signed 19-bit range) using a sequential restoring divider.
//   clk, reset   clock, synchronous active-high reset
//   bus          span_slope_setup_if.slave: in_* request channel,
//                out_* result channel (valid held until out_ready)
// Build option: define SLOPE_ROUND_EN to round half away from zero
// (dividend |diff| + LEN/2, one extra divider iteration).
module span_slope_setup
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  span_slope_setup_if.slave  bus
);

  localparam int unsigned DIFF_W = EFMSB + 2;
`ifdef SLOPE_ROUND_EN
  localparam int unsigned DVD_W  = EFMSB + 3;
`else
  localparam int unsigned DVD_W  = EFMSB + 2;
`endif
  localparam logic [DVD_W-1:0] POS_LIM = DVD_W'((2 ** EFMSB) - 1);
  localparam logic [DVD_W-1:0] NEG_LIM = DVD_W'(2 ** EFMSB);

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               sat_q;
  logic               err_q;
  logic               sign_q;
  coord_t             left_q;
  coord_t             mul_q;
  logic [DVD_W-1:0]   quo_q;

  logic               accept;
  logic signed [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0]  diff_abs;
  logic [DVD_W-1:0]   dividend;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [DVD_W-1:0]   div_quo;
  logic [EFMSB:0]     quo_neg;
  coord_t             mul_d;
  logic               sat_d;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    diff     = {bus.in_v1[EFMSB], bus.in_v1} - {bus.in_v0[EFMSB], bus.in_v0};
    diff_abs = diff[DIFF_W-1] ? DIFF_W'(-diff) : DIFF_W'(diff);
`ifdef SLOPE_ROUND_EN
    dividend = {1'b0, diff_abs} + DVD_W'(bus.in_len >> 1);
`else
    dividend = diff_abs;
`endif
    div_start = accept & (bus.in_len != '0) & ~div_busy;

    // Only the low bits are negated; anything large enough to need the
    // upper bits is clipped by the limit compare instead.
    quo_neg = ~quo_q[EFMSB:0] + 1'b1;
    sat_d   = 1'b0;
    if (sign_q) begin
      if (quo_q > NEG_LIM) begin
        mul_d = COORD_MIN;
        sat_d = 1'b1;
      end else begin
        mul_d = coord_t'(quo_neg);
      end
    end else begin
      if (quo_q > POS_LIM) begin
        mul_d = COORD_MAX;
        sat_d = 1'b1;
      end else begin
        mul_d = coord_t'(quo_q[EFMSB:0]);
      end
    end
  end

  udiv_seq #(
    .DVD_W (DVD_W),
    .DVS_W (SPAN_W)
  ) u_div (
    .clk_i      (clk),
    .rst_i      (reset),
    .start_i    (div_start),
    .dividend_i (dividend),
    .divisor_i  (bus.in_len),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
      sign_q      <= 1'b0;
      left_q      <= '0;
      mul_q       <= '0;
      quo_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            left_q     <= bus.in_v0;
            sign_q     <= diff[DIFF_W-1];
            in_ready_q <= 1'b0;
            sat_q      <= 1'b0;
            if (bus.in_len == '0) begin
              mul_q       <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          if (div_done) begin
            quo_q   <= div_quo;
            state_q <= FIX;
          end
        end
        FIX: begin
          mul_q       <= mul_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_left  = left_q;
  assign bus.out_mul   = mul_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_span_slope_setup.sv
// tb_span_slope_setup: directed bench for span_slope_setup (default build or
// with SLOPE_ROUND_EN defined).
module tb_span_slope_setup;
  import raster_pkg::*;

`ifdef SLOPE_ROUND_EN
  localparam int LAT = 23;
  localparam int RND = 1;
`else
  localparam int LAT = 22;
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  span_slope_setup_if bus ();

  span_slope_setup dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int v0;
    int v1;
    int len;
    int left;
    int mul;
    int sat;
    int err;
    int lat;   // posedges after the accept edge until out_valid is seen
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Presents one span; returns just after the accept edge.
  task automatic start_span(input int v0, input int v1, input int len);
    @(negedge clk);
    bus.in_v0    = coord_t'(v0);
    bus.in_v1    = coord_t'(v1);
    bus.in_len   = SPAN_W'(len);
    bus.in_valid = 1'b1;
    chk("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int rdy_seen);
    lat      = -1;
    rdy_seen = 0;
    if (bus.out_valid) begin
      lat = 0;
    end else begin
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        #1;
        if (bus.in_ready) rdy_seen = 1;
        if (bus.out_valid) begin
          lat = c;
          break;
        end
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", bus.out_valid, 0);
    chk("ready_back", bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int rdy;
    start_span(v.v0, v.v1, v.len);
    wait_valid(lat, rdy);
    chk($sformatf("lat[%0d]", idx), lat, v.lat);
    chk($sformatf("busy_ready[%0d]", idx), rdy, 0);
    chk($sformatf("left[%0d]", idx), bus.out_left, v.left);
    chk($sformatf("mul[%0d]", idx), bus.out_mul, v.mul);
    chk($sformatf("sat[%0d]", idx), bus.out_sat, v.sat);
    chk($sformatf("err[%0d]", idx), bus.out_err, v.err);
    release_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rdy;

    vecs[0]  = '{10,      650,     64, 10,      10,            0, 0, LAT};
    vecs[1]  = '{100,     -28,     64, 100,     -2,            0, 0, LAT};
    vecs[2]  = '{0,       63,      64, 0,       RND,           0, 0, LAT};
    vecs[3]  = '{-262144, 262143,  1,  -262144, 262143,        1, 0, LAT};
    vecs[4]  = '{5,       9,       0,  5,       0,             0, 1, 0};
    vecs[5]  = '{262143,  -262144, 1,  262143,  -262144,       1, 0, LAT};
    vecs[6]  = '{262143,  262143,  64, 262143,  0,             0, 0, LAT};
    vecs[7]  = '{-262144, -262144, 7,  -262144, 0,             0, 0, LAT};
    vecs[8]  = '{0,       -100,    7,  0,       -14,           0, 0, LAT};
    vecs[9]  = '{0,       100,     3,  0,       33,            0, 0, LAT};
    vecs[10] = '{0,       -262144, 1,  0,       -262144,       0, 0, LAT};
    vecs[11] = '{0,       262143,  1,  0,       262143,        0, 0, LAT};
    vecs[12] = '{1,       -262144, 1,  1,       -262144,       1, 0, LAT};
    vecs[13] = '{0,       1000,    64, 0,       (RND ? 16 : 15), 0, 0, LAT};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_v0     = '0;
    bus.in_v1     = '0;
    bus.in_len    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_left", bus.out_left, 0);
    chk("rst_mul", bus.out_mul, 0);
    chk("rst_sat", bus.out_sat, 0);
    chk("rst_err", bus.out_err, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Backpressure: result held for 10 cycles; new requests ignored.
    start_span(10, 650, 64);
    wait_valid(lat, rdy);
    chk("hold_lat", lat, LAT);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_v0    = coord_t'(77);
      bus.in_v1    = coord_t'(-500);
      bus.in_len   = SPAN_W'(3);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_left", bus.out_left, 10);
      chk("hold_mul", bus.out_mul, 10);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    release_out();

    // Reset in the middle of a divide.
    start_span(100, -28, 64);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_left", bus.out_left, 0);
    chk("abort_mul", bus.out_mul, 0);

    // A fresh span after the abort must complete normally.
    run_vec(vecs[1], 100);
    run_vec(vecs[4], 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
